// File: rtl/mul_arbiter_if.sv
// Requester/consumer bus for the shared 5x5 multiplier arbiter.
// A transfer happens on a clock edge where valid and ready are both high; valid must not wait on ready.
interface mul_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [5*NUM_REQ-1:0] req_a;
    logic [5*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 resp_valid;
    logic [NUM_REQ-1:0]   resp_id;
    logic [31:0]          resp_result;
    logic                 resp_balance;
    logic                 resp_ready;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_result, resp_balance
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_result, resp_balance
    );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one registered 5x5 multiplier among NUM_REQ requesters,
// one operation in flight: IDLE grants, WAIT covers the multiplier latency, RESP holds the answer.
module mul_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 1,
    parameter int CNT_WIDTH   = 16,
    localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    mul_arbiter_if.slave         bus,
    output logic [4:0]           mul_number1,
    output logic [4:0]           mul_number2,
    input  logic [31:0]          mul_result,
    input  logic                 mul_balance,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] done_count,
    output logic [1:0]           dbg_state,
    output logic [IDX_W-1:0]     dbg_rr_ptr
);
    localparam int CW = (MUL_LATENCY < 1) ? 1 : $clog2(MUL_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [4:0]           op_a_q, op_a_d;
    logic [4:0]           op_b_q, op_b_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [31:0]          result_q, result_d;
    logic                 balance_q, balance_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [NUM_REQ-1:0]   resp_id_q, resp_id_d;
    logic [CNT_WIDTH-1:0] done_q, done_d;
    logic                 bubble_q, bubble_d;

    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_found;
    logic                 accept;
    logic [NUM_REQ-1:0]   ready_oh;
    int                   cand;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!grant_found && bus.req_valid[IDX_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    // The cycle right after a response is taken is a forced bubble with no grant.
    assign accept   = (state_q == S_IDLE) && !bubble_q && !reset && grant_found;
    assign ready_oh = accept ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        balance_d    = balance_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        done_d       = done_q;
        bubble_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_a_d  = bus.req_a[5*int'(grant_idx) +: 5];
                    op_b_d  = bus.req_b[5*int'(grant_idx) +: 5];
                    owner_d = grant_idx;
                    cnt_d   = CW'(MUL_LATENCY);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    result_d     = mul_result;
                    balance_d    = mul_balance;
                    resp_valid_d = 1'b1;
                    resp_id_d    = NUM_REQ'(1) << owner_q;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_id_d    = '0;
                    rr_ptr_d     = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
                    done_d       = done_q + 1'b1;
                    bubble_d     = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            cnt_q        <= '0;
            result_q     <= '0;
            balance_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            done_q       <= '0;
            bubble_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            balance_q    <= balance_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            done_q       <= done_d;
            bubble_q     <= bubble_d;
        end
    end

    assign bus.req_ready    = ready_oh;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_id      = resp_id_q;
    assign bus.resp_result  = result_q;
    assign bus.resp_balance = balance_q;
    assign mul_number1      = op_a_q;
    assign mul_number2      = op_b_q;
    assign busy             = (state_q != S_IDLE);
    assign done_count       = done_q;
    assign dbg_state        = state_q;
    assign dbg_rr_ptr       = rr_ptr_q;
endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a behavioural 1-cycle 5x5 multiplier attached.
// Inputs change just after the falling edge; outputs are checked 1 ns later.
module tb_mul_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int CNT_WIDTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mul_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    logic [4:0]           mul_number1, mul_number2;
    logic [31:0]          mul_result;
    logic                 mul_balance;
    logic                 busy;
    logic [CNT_WIDTH-1:0] done_count;
    logic [1:0]           dbg_state;
    logic [1:0]           dbg_rr_ptr;

    int checks = 0;
    int errors = 0;

    mul_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LATENCY(1), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .mul_number1 (mul_number1),
        .mul_number2 (mul_number2),
        .mul_result  (mul_result),
        .mul_balance (mul_balance),
        .busy        (busy),
        .done_count  (done_count),
        .dbg_state   (dbg_state),
        .dbg_rr_ptr  (dbg_rr_ptr)
    );

    // Multiplier: 10-bit product sign-extended from bit 9, balance = even count of ones.
    logic [9:0] prod;
    assign prod = {5'd0, mul_number1} * {5'd0, mul_number2};
    always @(posedge clk) begin
        mul_result  <= {{22{prod[9]}}, prod};
        mul_balance <= ~^prod;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset          = 1'b1;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_op(input int id, input logic [4:0] a, input logic [4:0] b,
                         input logic [31:0] exp_r, input logic exp_bal, input string tag);
        int n;
        bus.req_valid           = NUM_REQ'(1) << id;
        bus.req_a               = '0;
        bus.req_b               = '0;
        bus.req_a[5*id +: 5]    = a;
        bus.req_b[5*id +: 5]    = b;
        bus.resp_ready          = 1'b0;
        n = 0;
        #1;
        while (bus.req_ready == '0 && n < 10) begin
            tick(); #1; n++;
        end
        check($sformatf("%s grant", tag), bus.req_ready, NUM_REQ'(1) << id);
        tick();
        bus.req_valid = '0;
        n = 0;
        #1;
        while (!bus.resp_valid && n < 10) begin
            tick(); #1; n++;
        end
        check($sformatf("%s resp_valid", tag), bus.resp_valid, 1'b1);
        check($sformatf("%s result", tag), bus.resp_result, exp_r);
        check($sformatf("%s balance", tag), bus.resp_balance, exp_bal);
        check($sformatf("%s resp_id", tag), bus.resp_id, NUM_REQ'(1) << id);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask

    logic [3:0] gnt_val [5];
    int         gnt_cyc [5];
    int         ng;
    int         n;
    logic [9:0] p;

    initial begin
        // Reset state, with requests pending that must not be granted during reset
        apply_reset();
        reset         = 1'b1;
        bus.req_valid = 4'b1111;
        #1;
        check("reset outputs",
              {bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_balance,
               busy, done_count, mul_number1, mul_number2, dbg_rr_ptr}, 64'd0);

        // 1: single request on requester 1, 5*3
        apply_reset();
        bus.req_valid      = 4'b0010;
        bus.req_a[9:5]     = 5'd5;
        bus.req_b[9:5]     = 5'd3;
        #1;
        check("t1 ready", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = '0;
        #1;
        check("t1 ready drop", bus.req_ready, 4'b0000);
        check("t1 busy", busy, 1'b1);
        check("t1 operands", {mul_number1, mul_number2}, {5'd5, 5'd3});
        check("t1 no resp c1", bus.resp_valid, 1'b0);
        tick(); #1;
        check("t1 no resp c2", bus.resp_valid, 1'b0);
        tick(); #1;
        check("t1 resp c3", bus.resp_valid, 1'b1);
        check("t1 resp_id", bus.resp_id, 4'b0010);
        check("t1 result", bus.resp_result, 32'h0000000F);
        check("t1 balance", bus.resp_balance, 1'b1);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        #1;
        check("t1 resp dropped", bus.resp_valid, 1'b0);
        check("t1 done_count", done_count, 4'd1);
        check("t1 rr_ptr", dbg_rr_ptr, 2'd2);
        check("t1 idle", busy, 1'b0);

        // 2: all requesters held, consumer always ready -> rotating grants 5 cycles apart
        apply_reset();
        bus.req_valid  = 4'b1111;
        bus.resp_ready = 1'b1;
        ng = 0;
        for (int i = 0; i < 5; i++) begin
            gnt_val[i] = '0;
            gnt_cyc[i] = -1;
        end
        for (int c = 0; c < 30; c++) begin
            #1;
            if (bus.req_ready != '0 && ng < 5) begin
                gnt_val[ng] = bus.req_ready;
                gnt_cyc[ng] = c;
                ng++;
            end
            tick();
        end
        check("t2 grant0", gnt_val[0], 4'b0001);
        check("t2 grant1", gnt_val[1], 4'b0010);
        check("t2 grant2", gnt_val[2], 4'b0100);
        check("t2 grant3", gnt_val[3], 4'b1000);
        check("t2 grant4", gnt_val[4], 4'b0001);
        for (int i = 0; i < 5; i++)
            check($sformatf("t2 grant%0d cycle", i), gnt_cyc[i], 5 * i);
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;

        // 3: largest operands, product sign-extends and has odd parity
        apply_reset();
        do_op(0, 5'd31, 5'd31, 32'hFFFFFFC1, 1'b0, "t3");

        // 4: consumer stalls for 6 cycles while everybody requests
        apply_reset();
        bus.req_valid = 4'b1111;
        bus.req_a     = {4{5'd3}};
        bus.req_b     = {4{5'd3}};
        n = 0;
        #1;
        while (!bus.resp_valid && n < 10) begin
            tick(); #1; n++;
        end
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t4 stall%0d", k),
                  {bus.resp_valid, bus.resp_id, bus.resp_balance, bus.resp_result, bus.req_ready},
                  {1'b1, 4'b0001, 1'b1, 32'd9, 4'b0000});
            tick(); #1;
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        #1;
        check("t4 bubble", bus.req_ready, 4'b0000);
        check("t4 rr_ptr", dbg_rr_ptr, 2'd1);
        tick(); #1;
        check("t4 next grant", bus.req_ready, 4'b0010);
        bus.req_valid = '0;

        // 5: reset while waiting on the multiplier discards the operation
        apply_reset();
        bus.req_valid    = 4'b0100;
        bus.req_a[14:10] = 5'd3;
        bus.req_b[14:10] = 5'd3;
        tick();
        bus.req_valid = '0;
        #1;
        check("t5 in wait", busy, 1'b1);
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t5 reset%0d", k),
                  {bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_balance,
                   busy, done_count, mul_number1, mul_number2}, 64'd0);
            tick(); #1;
        end
        reset = 1'b0;
        tick();
        do_op(2, 5'd2, 5'd2, 32'h00000004, 1'b0, "t5");
        #1;
        check("t5 done_count", done_count, 4'd1);

        // 6: 16 completions wrap the 4-bit done counter
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            p = 10'(i * (i + 1));
            do_op(i % 4, 5'(i), 5'(i + 1), {{22{p[9]}}, p}, ~^p, $sformatf("t6 op%0d", i));
            #1;
            if (i == 14) check("t6 count 15", done_count, 4'd15);
            if (i == 15) check("t6 count wrap", done_count, 4'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
